// File: rtl/axi_rd_responder.sv
// ============================================================================
// Module      : axi_rd_responder
// Description : AXI-style read subordinate returning R beats out of order,
//               with an ID-derived latency and ID-derived data per request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_responder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MIN_LAT    = 1,
  parameter int unsigned DATA_SEED  = 32'hA0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]      r_busy;
  logic [ID_WIDTH-1:0]   r_id  [DEPTH];
  logic [3:0]            r_cnt [DEPTH];
  logic                  r_rvalid;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_free_any;
  logic                  w_id_hit;
  logic                  w_elig_any;
  logic [IDX_W-1:0]      w_free_idx;
  logic [IDX_W-1:0]      w_elig_idx;
  logic [2:0]            w_arid_inv;
  logic [3:0]            w_lat;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_launch;
  logic [DATA_WIDTH-1:0] w_elig_data;

  // Descending scan so the lowest index wins both priority encoders.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_elig_any = 1'b0;
    w_elig_idx = '0;
    w_id_hit   = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_busy[i] && (r_cnt[i] == 4'd0)) begin
        w_elig_any = 1'b1;
        w_elig_idx = IDX_W'(i);
      end
      if (r_busy[i] && (r_id[i] == s_arid_i)) begin
        w_id_hit = 1'b1;
      end
    end
  end

  assign w_arid_inv  = ~s_arid_i[2:0];
  assign w_lat       = 4'(MIN_LAT) + {1'b0, w_arid_inv};
  assign s_arready_o = rst_n & w_free_any & ~w_id_hit;
  assign w_accept    = s_arvalid_i & s_arready_o;
  assign w_load      = ~r_rvalid | s_rready_i;
  assign w_launch    = w_load & w_elig_any;
  assign w_elig_data = DATA_WIDTH'(DATA_SEED + 32'(r_id[w_elig_idx]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_id[i]  <= '0;
        r_cnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (r_busy[i] && (r_cnt[i] != 4'd0)) begin
          r_cnt[i] <= r_cnt[i] - 4'd1;
        end
      end
      if (w_launch) begin
        r_busy[w_elig_idx] <= 1'b0;
      end
      // The allocated slot is idle beforehand, so it never collides with the launch slot.
      if (w_accept) begin
        r_busy[w_free_idx] <= 1'b1;
        r_id[w_free_idx]   <= s_arid_i;
        r_cnt[w_free_idx]  <= w_lat;
      end
      if (w_load) begin
        r_rvalid <= w_elig_any;
        if (w_elig_any) begin
          r_rid   <= r_id[w_elig_idx];
          r_rdata <= w_elig_data;
        end
      end
    end
  end

  assign s_rvalid_o = r_rvalid;
  assign s_rid_o    = r_rid;
  assign s_rdata_o  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_responder.sv
// ============================================================================
// Module      : tb_axi_rd_responder
// Description : Self-checking bench for axi_rd_responder against a
//               ready-time based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_rd_responder;

  localparam int DATA_WIDTH = 8;
  localparam int ID_WIDTH   = 4;
  localparam int DEPTH      = 4;
  localparam int MIN_LAT    = 1;
  localparam int DATA_SEED  = 'hA0;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [ID_WIDTH-1:0]   s_arid_i = '0;
  logic                  s_arvalid_i = 1'b0;
  logic                  s_arready_o;
  logic [DATA_WIDTH-1:0] s_rdata_o;
  logic [ID_WIDTH-1:0]   s_rid_o;
  logic                  s_rvalid_o;
  logic                  s_rready_i = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  axi_rd_responder #(
    .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH  (ID_WIDTH),
    .DEPTH     (DEPTH),
    .MIN_LAT   (MIN_LAT),
    .DATA_SEED (DATA_SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_arid_i   (s_arid_i),
    .s_arvalid_i(s_arvalid_i),
    .s_arready_o(s_arready_o),
    .s_rdata_o  (s_rdata_o),
    .s_rid_o    (s_rid_o),
    .s_rvalid_o (s_rvalid_o),
    .s_rready_i (s_rready_i)
  );

  always #5 clk = ~clk;

  // Reference model: each slot remembers the edge number at which it becomes due.
  bit m_busy     [DEPTH];
  int m_id       [DEPTH];
  int m_ready_at [DEPTH];
  int m_edge = 0;
  bit m_rvalid = 1'b0;
  int m_rid = 0;
  int m_rdata = 0;

  function automatic int lat_of(input int id);
    return MIN_LAT + (7 - (id % 8));
  endfunction

  function automatic int data_of(input int id);
    return (DATA_SEED + id) % (1 << DATA_WIDTH);
  endfunction

  function automatic bit exp_arready();
    bit any_free = 1'b0;
    bit hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_busy[i]) any_free = 1'b1;
      if (m_busy[i] && m_id[i] == int'(s_arid_i)) hit = 1'b1;
    end
    return rst_n && any_free && !hit;
  endfunction

  task automatic model_step();
    int fi;
    int ei;
    bit acc;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_busy[i] = 1'b0;
        m_id[i] = 0;
        m_ready_at[i] = 0;
      end
      m_rvalid = 1'b0;
      m_rid = 0;
      m_rdata = 0;
      return;
    end
    m_edge++;
    acc = s_arvalid_i && exp_arready();
    fi = -1;
    ei = -1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!m_busy[i]) fi = i;
      if (m_busy[i] && m_edge > m_ready_at[i]) ei = i;
    end
    if (!m_rvalid || s_rready_i) begin
      if (ei >= 0) begin
        m_rvalid = 1'b1;
        m_rid = m_id[ei];
        m_rdata = data_of(m_id[ei]);
        m_busy[ei] = 1'b0;
      end else begin
        m_rvalid = 1'b0;
      end
    end
    if (acc) begin
      m_busy[fi] = 1'b1;
      m_id[fi] = int'(s_arid_i);
      m_ready_at[fi] = m_edge + lat_of(int'(s_arid_i));
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("model_arready", int'(s_arready_o), int'(exp_arready()));
      check("model_rvalid", int'(s_rvalid_o), int'(m_rvalid));
      if (m_rvalid || !rst_n) begin
        check("model_rid", int'(s_rid_o), m_rid);
        check("model_rdata", int'(s_rdata_o), m_rdata);
      end
    end
  end

  task automatic send(input int id);
    s_arvalid_i = 1'b1;
    s_arid_i = ID_WIDTH'(id);
    @(negedge clk);
    s_arvalid_i = 1'b0;
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stall_count(input int id, input int exp_refused, input string name);
    int refused = 0;
    s_arvalid_i = 1'b1;
    s_arid_i = ID_WIDTH'(id);
    for (int c = 0; c < 30; c++) begin
      #1;
      if (s_arready_o) break;
      refused++;
      @(negedge clk);
    end
    @(negedge clk);
    s_arvalid_i = 1'b0;
    check(name, refused, exp_refused);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a pending request
    s_arvalid_i = 1'b1;
    s_arid_i = 4'd0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_arready", int'(s_arready_o), 0);
    check("rst_rvalid", int'(s_rvalid_o), 0);
    check("rst_rid", int'(s_rid_o), 0);
    check("rst_rdata", int'(s_rdata_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_arready", int'(s_arready_o), 1);
    @(negedge clk);
    s_arvalid_i = 1'b0;
    repeat (15) @(negedge clk);

    // Single request, id 2: latency 6, beat after edge k+7
    send(2);
    after_edges(6);
    check("single_early", int'(s_rvalid_o), 0);
    after_edges(1);
    check("single_rvalid", int'(s_rvalid_o), 1);
    check("single_rid", int'(s_rid_o), 2);
    check("single_rdata", int'(s_rdata_o), 'hA2);
    after_edges(1);
    check("single_done", int'(s_rvalid_o), 0);
    repeat (5) @(negedge clk);

    // Out of order: id 2 then id 6
    send(2);
    send(6);
    after_edges(3);
    check("ooo_first_valid", int'(s_rvalid_o), 1);
    check("ooo_first_rid", int'(s_rid_o), 6);
    check("ooo_first_rdata", int'(s_rdata_o), 'hA6);
    after_edges(3);
    check("ooo_second_rid", int'(s_rid_o), 2);
    check("ooo_second_rdata", int'(s_rdata_o), 'hA2);
    repeat (5) @(negedge clk);

    // Backpressure with a queued eligible beat behind it
    s_rready_i = 1'b0;
    send(6);
    send(5);
    after_edges(2);
    check("bp_rvalid", int'(s_rvalid_o), 1);
    for (int c = 0; c < 3; c++) begin
      after_edges(1);
      check("bp_hold_rid", int'(s_rid_o), 6);
      check("bp_hold_rdata", int'(s_rdata_o), 'hA6);
    end
    @(negedge clk);
    s_rready_i = 1'b1;
    after_edges(1);
    check("bp_next_valid", int'(s_rvalid_o), 1);
    check("bp_next_rid", int'(s_rid_o), 5);
    check("bp_next_rdata", int'(s_rdata_o), 'hA5);
    after_edges(1);
    check("bp_drained", int'(s_rvalid_o), 0);
    repeat (5) @(negedge clk);

    // Full table: ids 1..4 all fall due together, id 5 waits for the first launch
    send(1);
    send(2);
    send(3);
    send(4);
    #1;
    check("full_arready", int'(s_arready_o), 0);
    @(negedge clk);
    stall_count(5, 4, "full_stall_edges");

    // Same-ID stall: id 3 (latency 5) blocks a second id 3
    send(3);
    stall_count(3, 6, "same_id_stall_edges");

    // Mid-operation reset drops outstanding requests
    send(2);
    send(6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      after_edges(1);
      check("midrst_no_beat", int'(s_rvalid_o), 0);
    end
    @(negedge clk);

    // Randomised traffic with occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      s_arvalid_i = ($urandom_range(0, 9) < 6);
      s_arid_i = ID_WIDTH'($urandom_range(0, 15));
      s_rready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    s_arvalid_i = 1'b0;
    s_rready_i = 1'b1;
    repeat (20) @(negedge clk);
    #3;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
